// File: rtl/ps2_kbd_rx_fifo_pkg.sv
// Shared PS/2 keyboard constants, receiver state encoding and the event record
// carried through the event FIFO.
package ps2_kbd_rx_fifo_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  localparam int EVT_W = $bits(kbd_evt_t);

  function automatic logic is_prefix(input logic [7:0] c);
    case (c)
      PS2_E0, PS2_F0: return 1'b1;
      // Pause-sequence leader is passed on as a plain code
      PS2_E1:         return 1'b0;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_fifo_if.sv
// Keyboard event stream: valid/ready handshake plus the head event fields.
interface ps2_kbd_rx_fifo_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_kbd_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head value is held once the
// FIFO drains so downstream sees the last event rather than stale memory.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  assign o_rd_data = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (!o_empty) r_last <= r_mem[r_rd_ptr];
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: input sync + clock deglitch, frame FSM, E0/F0 prefix
// decoder and an event FIFO with sticky error flags.
module ps2_kbd_rx_fifo
  import ps2_kbd_rx_fifo_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kbd_clk,
  input  logic              kbd_data,
  ps2_kbd_rx_fifo_if.master evt,
  output logic              err_parity,
  output logic              err_frame,
  output logic              err_overflow,
  input  logic              err_clr
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic [FW-1:0]          r_fcnt;
  logic                   r_fclk, r_strobe;
  logic                   w_clk_s, w_data_s, w_flip;
  rx_state_t              r_state, w_state_nxt;
  logic [2:0]             r_bitcnt;
  logic [TW-1:0]          r_tmo;
  logic [7:0]             r_shift;
  logic                   r_par, r_byte_done;
  logic                   w_frame_err, w_par_err, w_done;
  logic                   r_ext, r_brk, r_wr_en;
  kbd_evt_t               r_wr_data, w_head;
  logic                   w_empty, w_full, w_pop, w_drop;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_flip   = (w_clk_s != r_fclk) && (r_fcnt == FW'(FILTER_LEN-1));

  // Synchronizers and kbd_clk deglitch; strobe marks a filtered falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_fcnt      <= '0;
      r_fclk      <= 1'b1;
      r_strobe    <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], kbd_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], kbd_data};
      r_strobe    <= w_flip && r_fclk;
      if (w_clk_s == r_fclk) begin
        r_fcnt <= '0;
      end else if (w_flip) begin
        r_fclk <= ~r_fclk;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_err = 1'b0;
    w_par_err   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:   if (r_strobe) begin
                   if (!w_data_s) w_state_nxt = ST_DATA;
                   else           w_frame_err = 1'b1;
                 end
      ST_DATA:   if (r_strobe && r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
      ST_PARITY: if (r_strobe) w_state_nxt = ST_STOP;
      ST_STOP:   if (r_strobe) begin
                   w_state_nxt = ST_IDLE;
                   if (!w_data_s)              w_frame_err = 1'b1;
                   else if (!(^{r_shift, r_par})) w_par_err = 1'b1;
                   else                        w_done      = 1'b1;
                 end
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && !r_strobe && r_tmo == TW'(TIMEOUT_CYCLES-1)) begin
      w_state_nxt = ST_IDLE;
      w_frame_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_tmo       <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_done <= w_done;
      if (r_state == ST_IDLE)                   r_bitcnt <= '0;
      else if (r_state == ST_DATA && r_strobe)  r_bitcnt <= r_bitcnt + 1'b1;
      if (r_state == ST_IDLE || r_strobe) r_tmo <= '0;
      else                                r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_strobe && r_state == ST_DATA)   r_shift <= {w_data_s, r_shift[7:1]};
    if (r_strobe && r_state == ST_PARITY) r_par   <= w_data_s;
    if (r_byte_done) r_wr_data <= '{ext: r_ext, brk: r_brk, code: r_shift};
  end

  // Prefix decoder: one cycle after byte_done the event is pushed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_frame_err || w_par_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_done) begin
        if (!is_prefix(r_shift)) begin
          r_wr_en <= 1'b1;
          r_ext   <= 1'b0;
          r_brk   <= 1'b0;
        end else if (r_shift == PS2_E0) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_wr_en),
    .i_wr_data (r_wr_data),
    .i_rd_en   (evt.evt_ready),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign w_pop         = evt.evt_ready && !w_empty;
  assign w_drop        = r_wr_en && w_full && !w_pop;
  assign evt.evt_valid = !w_empty;
  assign evt.evt_code  = w_head.code;
  assign evt.evt_ext   = w_head.ext;
  assign evt.evt_break = w_head.brk;

  // Sticky errors: a new error in the clear cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (w_par_err)     err_parity   <= 1'b1;
      else if (err_clr)  err_parity   <= 1'b0;
      if (w_frame_err)   err_frame    <= 1'b1;
      else if (err_clr)  err_frame    <= 1'b0;
      if (w_drop)        err_overflow <= 1'b1;
      else if (err_clr)  err_overflow <= 1'b0;
    end
  end

endmodule

// File: doc/ps2_kbd_rx_fifo.md
PS2_KBD_RX_FIFO -- requirements
Module: ps2_kbd_rx_fifo

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on kbd_clk/kbd_data (min 2).
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to change filtered kbd_clk (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a filtered falling edge before an in-progress frame aborts.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, min 2).
REQ-005 clk  input  1  system clock; one clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 kbd_clk  input  1  PS/2 clock, asynchronous.
REQ-008 kbd_data  input  1  PS/2 data, asynchronous.
REQ-009 evt_valid  output  1  FIFO non-empty.
REQ-010 evt_ready  input  1  consumer pop; pop occurs when evt_valid && evt_ready.
REQ-011 evt_code  output  8  scan code of head event.
REQ-012 evt_ext  output  1  head event was preceded by E0.
REQ-013 evt_break  output  1  head event was preceded by F0 (key release).
REQ-014 err_parity  output  1  sticky: frame with bad odd parity received.
REQ-015 err_frame  output  1  sticky: bad start/stop bit or timeout abort.
REQ-016 err_overflow  output  1  sticky: event dropped because FIFO full.
REQ-017 err_clr  input  1  one-cycle pulse clearing all three sticky errors.

Function
REQ-018 Inputs SHALL pass SYNC_STAGES flops; filtered kbd_clk SHALL toggle only after FILTER_LEN consecutive identical synchronized samples.
REQ-019 Falling edge of filtered kbd_clk SHALL be a one-cycle strobe; kbd_data sampled in that cycle.
REQ-020 Receiver FSM states: IDLE, DATA, PARITY, STOP; bit counter 0..7, LSB first.
REQ-021 IDLE: strobe with data=0 -> DATA; strobe with data=1 -> stay IDLE, set err_frame.
REQ-022 DATA: 8 strobes -> PARITY; PARITY: 1 strobe -> STOP; STOP: 1 strobe -> IDLE.
REQ-023 STOP: data=1 and odd parity over 9 bits correct -> byte_done pulse next cycle; parity wrong -> err_parity, no byte; stop=0 -> err_frame, no byte.
REQ-024 Non-IDLE with TIMEOUT_CYCLES cycles since last strobe -> IDLE, err_frame set, partial byte discarded; counter cleared on every strobe and in IDLE.
REQ-025 Decoder: byte E0 sets ext flag, F0 sets brk flag, no event; any other byte emits {ext,brk,code} and clears both flags; E1 treated as ordinary code.
REQ-026 Decoder flags SHALL clear on timeout or parity/frame error.
REQ-027 Event write SHALL occur the cycle after byte_done; evt_valid SHALL rise exactly 3 clk cycles after the strobe sampling the stop bit when FIFO was empty.
REQ-028 FIFO: first-word-fall-through; evt_* outputs reflect head while evt_valid=1, hold last value otherwise.
REQ-029 Full and write with no pop in same cycle: event dropped, err_overflow set; full with simultaneous pop: write accepted.
REQ-030 Empty: evt_ready ignored; pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-031 err_clr and a new error in same cycle: error wins (stays set).

Reset
REQ-032 rst SHALL force: FSM IDLE, bit counter 0, timeout 0, flags 0, FIFO empty, evt_valid 0, evt_code 0, evt_ext 0, evt_break 0, all err_* 0, filtered clk 1, synchronizers 1.
REQ-033 rst mid-frame SHALL discard partial byte and FIFO contents; reception resumes at next start bit after release.

Structure
REQ-034 Shared package SHALL hold PS/2 constants (E0, F0, E1 prefix codes), receiver state encoding, and event record type {ext,brk,code[7:0]}.
REQ-035 FIFO SHALL be a sub-module named sync_fifo, parameterised by width and depth.

Verification
REQ-036 Key 'A' press/release: frames 1C, F0, 1C -> two events {0,0,1C},{0,1,1C}; no errors.
REQ-037 Extended right arrow: E0 74, E0 F0 74 -> events {1,0,74},{1,1,74}.
REQ-038 Frame 1C with parity bit inverted -> no event, err_parity=1; err_clr -> 0; next good 1C -> event {0,0,1C}.
REQ-039 Stop after 5 data bits, wait TIMEOUT_CYCLES -> err_frame=1, FSM IDLE; following full frame 45 -> event {0,0,45}.
REQ-040 evt_ready=0, send FIFO_DEPTH+1 codes (16,1E,...) -> first 8 retained in order, err_overflow=1; full with pop+write same cycle -> no drop.
REQ-041 Glitch shorter than FILTER_LEN on kbd_clk mid-frame -> no extra bit; assert rst mid-frame -> outputs at reset values, next frame decoded correctly.
